// File: rtl/mips_boot_ctrl.sv
`timescale 1ns/1ps
// Purpose: boot/run sequencer for the pipelined MIPS32 core (clear GPRs, load program, init, run, time to HALT).
// Latency: start -> first RUN cycle = 1 + NREGS + LOAD cycles + 1; bad length reaches DONE one cycle after start.
// Backpressure: host port is valid/ready; host_ready is high only in LOAD and gaps in host_valid simply stall.
//
// Ports:
//   clk1, rst_n               controller clock, async active-low reset
//   start, prog_len           start pulse (IDLE/DONE only) and program length in words
//   host_valid/ready/data     program word stream from the host
//   mem_we/addr/wdata         instruction memory write port (driven only on a LOAD transfer)
//   reg_we/reg_addr           register file clear port (write data is implicitly 0)
//   core_init, core_run       one-cycle core init pulse; run enable (0 = stalled)
//   core_halted               core HALTED flag
//   busy, done, err, cycle_count  status: err 0=ok 1=bad length 2=timeout; RUN cycles of last run
module mips_boot_ctrl #(
  parameter int MEM_AW    = 10,
  parameter int NREGS     = 32,
  parameter int TIMEOUT   = 4096,
  parameter int HALT_MASK = 2
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MEM_AW:0]   prog_len,
  input  logic              host_valid,
  input  logic [31:0]       host_data,
  output logic              host_ready,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              reg_we,
  output logic [4:0]        reg_addr,
  output logic              core_init,
  output logic              core_run,
  input  logic              core_halted,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [31:0]       cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD, S_INIT, S_RUN, S_DONE
  } state_t;

  localparam logic [MEM_AW:0] MAX_LEN   = {1'b1, {MEM_AW{1'b0}}};
  localparam logic [MEM_AW:0] ONE_W     = {{MEM_AW{1'b0}}, 1'b1};
  localparam logic [4:0]      LAST_REG  = 5'(NREGS - 1);
  localparam logic [31:0]     TIMEOUT_C = 32'(TIMEOUT);
  localparam logic [31:0]     HMASK_C   = 32'(HALT_MASK);

  state_t          state_q, state_d;
  logic [4:0]      reg_cnt_q, reg_cnt_d;
  logic [MEM_AW:0] word_cnt_q, word_cnt_d;
  logic [MEM_AW:0] len_q, len_d;
  logic [1:0]      err_q, err_d;
  logic [31:0]     cyc_q, cyc_d;
  logic [31:0]     cyc_inc;
  logic            xfer;
  logic            len_bad;
  logic            halt_ok;

  assign xfer    = (state_q == S_LOAD) && host_valid;
  assign len_bad = (prog_len == '0) || (prog_len > MAX_LEN);
  // Saturating RUN counter; value after the current RUN cycle.
  assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
  // The core's HALTED flag may be stale from a previous run for the first
  // HALT_MASK cycles, so it only counts once the guard window has passed.
  assign halt_ok = core_halted && (cyc_q >= HMASK_C);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      reg_cnt_q  <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      err_q      <= '0;
      cyc_q      <= '0;
    end else begin
      state_q    <= state_d;
      reg_cnt_q  <= reg_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      err_q      <= err_d;
      cyc_q      <= cyc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    reg_cnt_d  = reg_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    err_d      = err_q;
    cyc_d      = cyc_q;
    host_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    reg_we     = 1'b0;
    reg_addr   = '0;
    core_init  = 1'b0;
    core_run   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        busy = 1'b0;
        done = (state_q == S_DONE);
        if (start) begin
          if (len_bad) begin
            // cycle_count deliberately kept from the previous run
            state_d = S_DONE;
            err_d   = 2'd1;
          end else begin
            state_d    = S_CLR;
            len_d      = prog_len;
            err_d      = 2'd0;
            cyc_d      = '0;
            reg_cnt_d  = '0;
            word_cnt_d = '0;
          end
        end
      end
      S_CLR: begin
        reg_we    = 1'b1;
        reg_addr  = reg_cnt_q;
        reg_cnt_d = reg_cnt_q + 5'd1;
        if (reg_cnt_q == LAST_REG) state_d = S_LOAD;
      end
      S_LOAD: begin
        host_ready = 1'b1;
        if (xfer) begin
          mem_we     = 1'b1;
          mem_addr   = word_cnt_q[MEM_AW-1:0];
          mem_wdata  = host_data;
          word_cnt_d = word_cnt_q + ONE_W;
          if (word_cnt_q == len_q - ONE_W) state_d = S_INIT;
        end
      end
      S_INIT: begin
        core_init = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        core_run = 1'b1;
        cyc_d    = cyc_inc;
        // Halt takes priority over a simultaneous timeout.
        if (halt_ok) begin
          state_d = S_DONE;
          err_d   = 2'd0;
        end else if (cyc_inc >= TIMEOUT_C) begin
          state_d = S_DONE;
          err_d   = 2'd2;
        end
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign err         = err_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_mips_boot_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for mips_boot_ctrl: directed and randomized runs
// against a behavioural model of the boot/run sequence.
module tb_mips_boot_ctrl;
  localparam int MEM_AW    = 10;
  localparam int NREGS     = 32;
  localparam int TIMEOUT   = 4096;
  localparam int HALT_MASK = 2;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [MEM_AW:0]   prog_len = '0;
  logic              host_valid = 1'b0;
  logic [31:0]       host_data = '0;
  logic              host_ready;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              reg_we;
  logic [4:0]        reg_addr;
  logic              core_init;
  logic              core_run;
  logic              core_halted = 1'b0;
  logic              busy;
  logic              done;
  logic [1:0]        err;
  logic [31:0]       cycle_count;

  always #5 clk1 = ~clk1;

  mips_boot_ctrl #(
    .MEM_AW(MEM_AW), .NREGS(NREGS), .TIMEOUT(TIMEOUT), .HALT_MASK(HALT_MASK)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .prog_len(prog_len),
    .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .reg_we(reg_we), .reg_addr(reg_addr), .core_init(core_init),
    .core_run(core_run), .core_halted(core_halted), .busy(busy),
    .done(done), .err(err), .cycle_count(cycle_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- observation ----------------
  int          ncyc = 0;
  bit          rec = 1'b0;
  int          start_neg, run_neg, done_neg;
  int          n_init, n_load, n_gap, n_run, feed_idx, bad_we;
  int          reg_q[$];
  int          ma_q[$];
  logic [31:0] md_q[$];
  logic [31:0] prog [0:1023];
  int          last_cyc = 0;  // cycle_count the DUT should be holding

  task automatic clear_mon();
    start_neg = -1; run_neg = -1; done_neg = -1;
    n_init = 0; n_load = 0; n_gap = 0; n_run = 0; feed_idx = 0; bad_we = 0;
    reg_q.delete(); ma_q.delete(); md_q.delete();
  endtask

  always @(negedge clk1) begin
    ncyc++;
    if (rec) begin
      if (start && start_neg < 0) start_neg = ncyc;
      if (reg_we) reg_q.push_back(int'(reg_addr));
      if (mem_we) begin
        ma_q.push_back(int'(mem_addr));
        md_q.push_back(mem_wdata);
        if (!(host_valid && host_ready)) bad_we++;
      end
      if (core_init) begin
        n_init++;
        if (core_run) bad_we++;
      end
      if (host_ready) begin
        n_load++;
        if (!host_valid) n_gap++;
      end
      if (core_run) begin
        if (run_neg < 0) run_neg = ncyc;
        n_run++;
      end
      if (done && start_neg >= 0 && ncyc > start_neg && done_neg < 0) done_neg = ncyc;
      if (host_valid && host_ready) feed_idx++;
    end
  end

  // ---------------- reference model ----------------
  function automatic bit halted_at(input int hmode, input int hat, input int k);
    return (hmode == 1) || (hmode == 2 && k >= hat);
  endfunction

  // First RUN cycle index k >= HALT_MASK seeing halt ends the run with k+1
  // cycles; otherwise the run is cut at TIMEOUT cycles with err=2.
  task automatic model_run(input int hmode, input int hat, output int ecyc, output int eerr);
    ecyc = TIMEOUT;
    eerr = 2;
    for (int k = 0; k < TIMEOUT; k++) begin
      if (k >= HALT_MASK && halted_at(hmode, hat, k)) begin
        ecyc = k + 1;
        eerr = 0;
        break;
      end
    end
  endtask

  task automatic drive_cycle(input int len, input int vmode, input int hmode, input int hat);
    bit more;
    bit pat;
    more = feed_idx < len;
    case (vmode)
      0:       pat = 1'b1;
      1:       pat = (n_load % 2) == 1;
      default: pat = 1'($urandom_range(0, 1));
    endcase
    host_valid  = more && pat;
    host_data   = more ? prog[feed_idx] : $urandom;
    core_halted = halted_at(hmode, hat, n_run);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, ".outs"}, {host_ready, mem_we, mem_addr, mem_wdata, reg_we, reg_addr,
                         core_init, core_run, busy, done, err}, 64'd0);
    chk({tag, ".cyc"}, cycle_count, 64'd0);
  endtask

  task automatic run_case(input string name, input int len, input int vmode, input int hmode,
                          input int hat, input bit inject, input int rst_at);
    int  ecyc, eerr, eload, nerr;
    bit  injected;
    bit  was_reset;
    bit  got_done;
    injected  = 1'b0;
    was_reset = 1'b0;
    got_done  = 1'b0;
    @(posedge clk1); #1;
    clear_mon();
    rec = 1'b1;
    start = 1'b1;
    prog_len = (MEM_AW+1)'(len);
    drive_cycle(len, vmode, hmode, hat);
    for (int b = 0; b < 12000; b++) begin
      @(posedge clk1); #1;
      if (done_neg >= 0) begin
        got_done = 1'b1;
        break;
      end
      start = 1'b0;
      if (inject && !injected && n_load == 3) begin
        start = 1'b1;
        prog_len = (MEM_AW+1)'(len + 5);
        injected = 1'b1;
      end
      if (rst_at > 0 && feed_idx == rst_at) begin
        rst_n = 1'b0;
        host_valid = 1'b0;
        core_halted = 1'b0;
        #1;
        chk_zero_outs({name, ".async_rst"});
        rec = 1'b0;
        @(negedge clk1);
        rst_n = 1'b1;
        was_reset = 1'b1;
        break;
      end
      drive_cycle(len, vmode, hmode, hat);
    end
    rec = 1'b0;
    start = 1'b0;
    host_valid = 1'b0;
    core_halted = 1'b0;

    if (was_reset) begin
      last_cyc = 0;
      chk({name, ".words_before_rst"}, ma_q.size(), rst_at);
      return;
    end

    chk({name, ".done_seen"}, got_done, 1);
    model_run(hmode, hat, ecyc, eerr);
    case (vmode)
      0:       eload = len;
      1:       eload = 2 * len;
      default: eload = len + n_gap;
    endcase
    chk({name, ".done"}, done, 1);
    chk({name, ".busy"}, busy, 0);
    chk({name, ".core_run"}, core_run, 0);
    chk({name, ".err"}, err, eerr);
    chk({name, ".cycle_count"}, cycle_count, ecyc);
    chk({name, ".init_pulses"}, n_init, 1);
    chk({name, ".load_cycles"}, n_load, eload);
    chk({name, ".latency"}, run_neg - start_neg, 1 + NREGS + eload + 1);
    chk({name, ".reg_we_count"}, reg_q.size(), NREGS);
    nerr = 0;
    foreach (reg_q[i]) if (reg_q[i] != i) nerr++;
    chk({name, ".reg_seq"}, nerr, 0);
    chk({name, ".mem_we_count"}, ma_q.size(), len);
    nerr = 0;
    foreach (ma_q[i]) if (ma_q[i] != i || md_q[i] !== prog[i]) nerr++;
    chk({name, ".mem_seq"}, nerr, 0);
    chk({name, ".stray_we"}, bad_we, 0);
    last_cyc = ecyc;
  endtask

  task automatic bad_len(input string name, input int len);
    @(posedge clk1); #1;
    clear_mon();
    rec = 1'b1;
    start = 1'b1;
    prog_len = (MEM_AW+1)'(len);
    host_valid = 1'b1;
    host_data = $urandom;
    repeat (4) begin
      @(posedge clk1); #1;
      start = 1'b0;
    end
    rec = 1'b0;
    host_valid = 1'b0;
    chk({name, ".latency"}, done_neg - start_neg, 1);
    chk({name, ".done"}, done, 1);
    chk({name, ".busy"}, busy, 0);
    chk({name, ".err"}, err, 1);
    chk({name, ".cycle_count"}, cycle_count, last_cyc);
    chk({name, ".reg_we_count"}, reg_q.size(), 0);
    chk({name, ".mem_we_count"}, ma_q.size(), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] nominal [0:8];
    int len, vm, hm, hat;
    nominal = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    for (int i = 0; i < 1024; i++) prog[i] = $urandom;
    for (int i = 0; i < 9; i++) prog[i] = nominal[i];

    host_valid = 1'b1;
    #2;
    chk_zero_outs("reset");
    repeat (3) @(negedge clk1);
    rst_n = 1'b1;

    bad_len("badlen0", 0);
    bad_len("badlen1025", 1025);
    run_case("nominal", 9, 0, 2, 20, 1'b0, 0);
    run_case("gaps", 9, 1, 2, 20, 1'b0, 0);
    bad_len("badlen2047", 2047);
    run_case("halt_guard", 9, 0, 1, 0, 1'b0, 0);
    run_case("busy_start", 9, 0, 2, 5, 1'b1, 0);
    run_case("timeout", 3, 0, 0, 0, 1'b0, 0);
    run_case("halt_at_timeout", 2, 0, 2, TIMEOUT - 1, 1'b0, 0);
    run_case("mid_reset", 9, 0, 2, 10, 1'b0, 5);
    run_case("after_reset", 9, 2, 2, 7, 1'b0, 0);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 1024; i++) prog[i] = $urandom;
      len = $urandom_range(1, 20);
      vm  = $urandom_range(0, 2);
      hm  = $urandom_range(1, 2);
      hat = $urandom_range(0, 40);
      run_case($sformatf("rand%0d", t), len, vm, hm, hat, 1'b0, 0);
    end
    run_case("max_len", 1024, 0, 2, 3, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_boot_ctrl.md
Name: mips_boot_ctrl

Overview:
- Boot/run sequencer for the pipelined MIPS32 core; replaces ad-hoc hierarchical preloading of register file, instruction memory, PC and halt state.
- On `start`: clears all GPRs, streams a program from a host valid/ready port into instruction memory, initialises the core, releases it, then times execution until HALT.
- Reports busy/done, execution cycle count and error status.
- Sits between the host/test harness and the core's memory/register write ports.

Parameters:
- MEM_AW, 10, instruction memory address width (depth 2**MEM_AW words)
- NREGS, 32, number of GPRs to clear
- TIMEOUT, 4096, maximum RUN cycles before the error abort
- HALT_MASK, 2, RUN cycles during which `core_halted` is ignored (stale-flag guard)

Ports:
- clk1  in  1  single controller clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle start pulse; honoured only in IDLE or DONE
- prog_len  in  MEM_AW+1  program length in words, sampled on accepted start
- host_valid  in  1  host word valid
- host_data  in  32  instruction word
- host_ready  out  1  controller accepts a word this cycle
- mem_we  out  1  instruction memory write enable
- mem_addr  out  MEM_AW  instruction memory write address
- mem_wdata  out  32  instruction memory write data
- reg_we  out  1  register file write enable (data is always 0)
- reg_addr  out  5  register index being cleared
- core_init  out  1  one-cycle pulse: core sets PC=0, HALTED=0, TAKEN_BRANCH=0
- core_run  out  1  core may advance; 0 holds the core stalled
- core_halted  in  1  core HALTED flag
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- err  out  2  0 = ok, 1 = bad length, 2 = timeout
- cycle_count  out  32  RUN cycles of the last run

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset asserted mid-operation aborts immediately; memory and register contents are left as written so far.
- States: IDLE, CLR, LOAD, INIT, RUN, DONE.
- IDLE/DONE, on start:
  - If prog_len == 0 or prog_len > 2**MEM_AW: go to DONE with err=1 and cycle_count unchanged.
  - Otherwise latch prog_len, clear err and cycle_count, go to CLR.
- start in any other state is ignored.
- CLR:
  - reg_we=1 with reg_addr = 0..NREGS-1, one per cycle (exactly NREGS cycles).
  - Next state is LOAD after the cycle with reg_addr = NREGS-1.
- LOAD:
  - host_ready=1.
  - A transfer occurs on host_valid & host_ready. In that same cycle (combinational): mem_we=1, mem_addr = word counter, mem_wdata = host_data.
  - The counter starts at 0 and increments per transfer. host_valid gaps stall without side effects.
  - After the transfer of word prog_len-1, host_ready drops in the next cycle and the state moves to INIT.
  - mem_we is never asserted outside a LOAD transfer.
- INIT:
  - One cycle with core_init=1 and core_run=0.
  - Next state RUN.
- RUN:
  - core_run=1; cycle_count increments every RUN cycle, saturating at 2**32-1.
  - core_halted is ignored while cycle_count < HALT_MASK.
  - After that, core_halted=1 moves to DONE with err=0. cycle_count holds its value including the cycle in which halt was sampled.
  - If cycle_count reaches TIMEOUT without halt: go to DONE with err=2, core_run=0.
  - Halt and timeout in the same cycle: halt wins (err=0).
- DONE:
  - done=1, core_run=0. err and cycle_count are held until the next accepted start.
  - start re-runs the full sequence, including CLR.
- Total latency from start to first RUN cycle = 1 + NREGS + (LOAD cycles) + 1.

Test Plan:
- Nominal run:
  - Stimulus: start, prog_len=9, words 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 with host_valid always high; model asserts core_halted 20 cycles into RUN.
  - Required: 32 reg_we pulses at addr 0..31; 9 mem_we pulses at addr 0..8 with matching data; one core_init pulse; done=1, err=0, cycle_count=21.
- Host gaps: same program with host_valid low on alternate cycles -> mem_we only on valid cycles; addresses still contiguous 0..8; 18 LOAD cycles.
- Bad length:
  - prog_len=0 -> DONE in 1 cycle, err=1, no reg_we or mem_we.
  - prog_len=1025 -> same result.
- Timeout and halt guard:
  - core_halted stuck 0 -> done with err=2, cycle_count=4096, core_run=0.
  - core_halted stuck 1 from entry to RUN -> halt accepted only after HALT_MASK cycles; cycle_count=3.
- start while busy: pulse start during LOAD -> ignored; prog_len not re-latched; sequence completes normally.
- Reset mid-load: rst_n low after word 4 -> all outputs 0 asynchronously, IDLE; a new start restarts from CLR with addr 0.
